// File: rtl/dma_ram_axis_pkg.sv
// Shared constants and state encoding for the DMA staging RAM reader.
// Default row geometry matches two 256-bit segments.
package dma_ram_axis_pkg;

  localparam int ROW_BYTES = 64;
  localparam logic [3:0] DMA_ERROR_NONE = 4'h0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    STATUS = 2'd2
  } dma_state_e;

endpackage

// File: rtl/dma_ram_axis_reader_if.sv
// Descriptor, completion-status and AXI-Stream signals of the RAM reader.
// Handshakes: a transfer happens on a rising clk edge where valid and ready are both 1;
// valid never waits on ready, and payload is held stable while valid=1 and ready=0.
interface dma_ram_axis_reader_if #(
  parameter int DATA_BYTES = 64,
  parameter int ADDR_WIDTH = 14,
  parameter int LEN_WIDTH  = 16,
  parameter int TAG_WIDTH  = 8,
  parameter int ID_WIDTH   = 8
);

  logic [ADDR_WIDTH-1:0]   s_desc_ram_addr;
  logic [LEN_WIDTH-1:0]    s_desc_len;
  logic [TAG_WIDTH-1:0]    s_desc_tag;
  logic [ID_WIDTH-1:0]     s_desc_id;
  logic                    s_desc_valid;
  logic                    s_desc_ready;

  logic [TAG_WIDTH-1:0]    m_status_tag;
  logic [3:0]              m_status_error;
  logic                    m_status_valid;

  logic [8*DATA_BYTES-1:0] m_axis_tdata;
  logic [DATA_BYTES-1:0]   m_axis_tkeep;
  logic                    m_axis_tvalid;
  logic                    m_axis_tready;
  logic                    m_axis_tlast;
  logic [ID_WIDTH-1:0]     m_axis_tid;

  modport master (
    input  s_desc_ram_addr, s_desc_len, s_desc_tag, s_desc_id, s_desc_valid,
    output s_desc_ready,
    output m_status_tag, m_status_error, m_status_valid,
    output m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tid,
    input  m_axis_tready
  );

  modport slave (
    output s_desc_ram_addr, s_desc_len, s_desc_tag, s_desc_id, s_desc_valid,
    input  s_desc_ready,
    input  m_status_tag, m_status_error, m_status_valid,
    input  m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tid,
    output m_axis_tready
  );

endinterface

// File: rtl/dma_seg_ram.sv
// One RAM segment: byte-masked write port plus a PIPELINE-deep registered read port.
// Read responses carry no ready; the consumer reserves space before issuing.
module dma_seg_ram #(
  parameter int DATA_WIDTH = 256,
  parameter int BE_WIDTH   = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int PIPELINE   = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [BE_WIDTH-1:0]   wr_be,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic                  wr_done,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_cmd_valid,
  output logic                  rd_cmd_ready,
  output logic [DATA_WIDTH-1:0] rd_resp_data,
  output logic                  rd_resp_valid
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] pipe_data [PIPELINE];
  logic [PIPELINE-1:0]   pipe_valid;

  assign wr_ready     = rstn;
  assign rd_cmd_ready = rstn;

  // Read and write share one process so a same-row read sees the pre-write contents.
  always_ff @(posedge clk) begin
    if (wr_valid && wr_ready) begin
      for (int b = 0; b < BE_WIDTH; b++) begin
        if (wr_be[b]) mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
    pipe_data[0] <= mem[rd_addr];
    for (int i = 1; i < PIPELINE; i++) pipe_data[i] <= pipe_data[i-1];
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pipe_valid <= '0;
      wr_done    <= 1'b0;
    end else begin
      pipe_valid[0] <= rd_cmd_valid && rd_cmd_ready;
      for (int i = 1; i < PIPELINE; i++) pipe_valid[i] <= pipe_valid[i-1];
      wr_done <= wr_valid && wr_ready;
    end
  end

  assign rd_resp_data  = pipe_data[PIPELINE-1];
  assign rd_resp_valid = pipe_valid[PIPELINE-1];

endmodule

// File: rtl/dma_ram_axis_reader.sv
// Segmented staging RAM written by the DMA engine, streamed out per descriptor
// as AXI-Stream rows with a one-cycle completion status.
module dma_ram_axis_reader
  import dma_ram_axis_pkg::*;
#(
  parameter int SIZE           = 16384,
  parameter int SEG_COUNT      = 2,
  parameter int SEG_DATA_WIDTH = 256,
  parameter int SEG_BE_WIDTH   = 32,
  parameter int SEG_ADDR_WIDTH = 8,
  parameter int RAM_ADDR_WIDTH = 14,
  parameter int PIPELINE       = 2,
  parameter int ID_WIDTH       = 8,
  parameter int LEN_WIDTH      = 16,
  parameter int TAG_WIDTH      = 8
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic [SEG_COUNT*SEG_BE_WIDTH-1:0]     wr_cmd_be,
  input  logic [SEG_COUNT*SEG_ADDR_WIDTH-1:0]   wr_cmd_addr,
  input  logic [SEG_COUNT*SEG_DATA_WIDTH-1:0]   wr_cmd_data,
  input  logic [SEG_COUNT-1:0]                  wr_cmd_valid,
  output logic [SEG_COUNT-1:0]                  wr_cmd_ready,
  output logic [SEG_COUNT-1:0]                  wr_done,
  input  logic                                  enable,
  output logic [1:0]                            state_dbg,
  dma_ram_axis_reader_if.master                 bus
);

  localparam int ROW_W      = SEG_COUNT * SEG_BE_WIDTH;
  localparam int ROW_SHIFT  = $clog2(ROW_W);
  localparam int FIFO_DEPTH = PIPELINE + 2;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_ACTIVE = ACTIVE;
  localparam logic [1:0] ST_STATUS = STATUS;

  logic [1:0]                state;
  logic [SEG_ADDR_WIDTH-1:0] row_addr;
  logic [LEN_WIDTH-1:0]      issue_left;
  logic [LEN_WIDTH-1:0]      out_left;
  logic [ROW_W-1:0]          last_keep;
  logic [TAG_WIDTH-1:0]      tag_q;
  logic [ID_WIDTH-1:0]       id_q;
  logic [CNT_W-1:0]          credit;

  logic [8*ROW_W-1:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]          wr_ptr;
  logic [PTR_W-1:0]          rd_ptr;
  logic [CNT_W-1:0]          fifo_cnt;

  logic [SEG_COUNT-1:0]      seg_rd_ready;
  logic [SEG_COUNT-1:0]      seg_resp_valid;
  logic [8*ROW_W-1:0]        resp_data;

  logic                      desc_fire;
  logic                      issue;
  logic                      push;
  logic                      pop;
  logic [LEN_WIDTH:0]        len_round;
  logic [LEN_WIDTH-1:0]      desc_beats;
  logic [ROW_SHIFT-1:0]      len_rem;
  logic                      unused_addr_low;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Every row of a descriptor occupies the same row address in all segments.
  for (genvar s = 0; s < SEG_COUNT; s++) begin : g_seg
    dma_seg_ram #(
      .DATA_WIDTH (SEG_DATA_WIDTH),
      .BE_WIDTH   (SEG_BE_WIDTH),
      .ADDR_WIDTH (SEG_ADDR_WIDTH),
      .PIPELINE   (PIPELINE)
    ) u_seg (
      .clk           (clk),
      .rstn          (rstn),
      .wr_be         (wr_cmd_be[s*SEG_BE_WIDTH +: SEG_BE_WIDTH]),
      .wr_addr       (wr_cmd_addr[s*SEG_ADDR_WIDTH +: SEG_ADDR_WIDTH]),
      .wr_data       (wr_cmd_data[s*SEG_DATA_WIDTH +: SEG_DATA_WIDTH]),
      .wr_valid      (wr_cmd_valid[s]),
      .wr_ready      (wr_cmd_ready[s]),
      .wr_done       (wr_done[s]),
      .rd_addr       (row_addr),
      .rd_cmd_valid  (issue),
      .rd_cmd_ready  (seg_rd_ready[s]),
      .rd_resp_data  (resp_data[s*SEG_DATA_WIDTH +: SEG_DATA_WIDTH]),
      .rd_resp_valid (seg_resp_valid[s])
    );
  end

  assign unused_addr_low = ^bus.s_desc_ram_addr[ROW_SHIFT-1:0];

  assign len_round  = {1'b0, bus.s_desc_len} + (LEN_WIDTH+1)'(ROW_W - 1);
  assign desc_beats = LEN_WIDTH'(len_round >> ROW_SHIFT);
  assign len_rem    = bus.s_desc_len[ROW_SHIFT-1:0];

  assign desc_fire = bus.s_desc_valid && bus.s_desc_ready;
  // Credits cover reads still in the RAM pipeline plus rows parked in the FIFO.
  assign issue = (state == ST_ACTIVE) && (issue_left != '0) &&
                 (credit < CNT_W'(FIFO_DEPTH)) && (&seg_rd_ready);
  assign push  = &seg_resp_valid;
  assign pop   = bus.m_axis_tvalid && bus.m_axis_tready;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (desc_fire) begin
            row_addr   <= bus.s_desc_ram_addr[ROW_SHIFT +: SEG_ADDR_WIDTH];
            issue_left <= desc_beats;
            out_left   <= desc_beats;
            last_keep  <= (len_rem == '0) ? '1 : (ROW_W'(1) << len_rem) - ROW_W'(1);
            tag_q      <= bus.s_desc_tag;
            id_q       <= bus.s_desc_id;
            state      <= (desc_beats == '0) ? ST_STATUS : ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (issue) begin
            row_addr   <= row_addr + 1'b1;
            issue_left <= issue_left - 1'b1;
          end
          if (pop) begin
            out_left <= out_left - 1'b1;
            if (out_left == LEN_WIDTH'(1)) state <= ST_STATUS;
          end
        end
        ST_STATUS: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      credit   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      credit   <= credit + CNT_W'(issue) - CNT_W'(pop);
      fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= resp_data;
  end

  assign bus.s_desc_ready   = rstn && enable && (state == ST_IDLE);
  assign bus.m_status_valid = (state == ST_STATUS);
  assign bus.m_status_tag   = tag_q;
  assign bus.m_status_error = DMA_ERROR_NONE;

  assign bus.m_axis_tvalid = (fifo_cnt != '0);
  assign bus.m_axis_tdata  = fifo_mem[rd_ptr];
  assign bus.m_axis_tlast  = (out_left == LEN_WIDTH'(1));
  assign bus.m_axis_tkeep  = bus.m_axis_tlast ? last_keep : '1;
  assign bus.m_axis_tid    = id_q;

  assign state_dbg = state;

endmodule

// File: tb/tb_dma_ram_axis_reader.sv
// Directed bench for dma_ram_axis_reader: a RAM byte model feeds an expected-beat
// queue; independent monitors pop and compare stream beats and status pulses.
module tb_dma_ram_axis_reader;

  localparam int W = 8 + 1 + 64 + 512;

  logic         clk;
  logic         rstn;
  logic [63:0]  wr_cmd_be;
  logic [15:0]  wr_cmd_addr;
  logic [511:0] wr_cmd_data;
  logic [1:0]   wr_cmd_valid;
  logic [1:0]   wr_cmd_ready;
  logic [1:0]   wr_done;
  logic         enable;
  logic [1:0]   state_dbg;

  dma_ram_axis_reader_if #(.DATA_BYTES(64), .ADDR_WIDTH(14), .LEN_WIDTH(16),
                           .TAG_WIDTH(8), .ID_WIDTH(8)) bus ();

  dma_ram_axis_reader dut (
    .clk          (clk),
    .rstn         (rstn),
    .wr_cmd_be    (wr_cmd_be),
    .wr_cmd_addr  (wr_cmd_addr),
    .wr_cmd_data  (wr_cmd_data),
    .wr_cmd_valid (wr_cmd_valid),
    .wr_cmd_ready (wr_cmd_ready),
    .wr_done      (wr_done),
    .enable       (enable),
    .state_dbg    (state_dbg),
    .bus          (bus.master)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [W-1:0]  exp_q[$];
  logic [11:0]   stat_q[$];
  logic [7:0]    mem_model [16384];
  int            tready_mode = 1;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // tready driver: 0 = manual, 1 = always ready, 2 = random
  initial begin
    bus.m_axis_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (tready_mode == 1) bus.m_axis_tready = 1'b1;
      else if (tready_mode == 2) bus.m_axis_tready = 1'($urandom_range(0, 1));
    end
  end

  // stream and status monitor
  logic [W-1:0] held;
  logic         prev_stall = 1'b0;
  initial begin
    logic [W-1:0]  act;
    logic [W-1:0]  exp;
    logic [11:0]   sact;
    forever begin
      @(negedge clk);
      act = {bus.m_axis_tid, bus.m_axis_tlast, bus.m_axis_tkeep, bus.m_axis_tdata};
      if (rstn && prev_stall && bus.m_axis_tvalid) begin
        checks++;
        if (act !== held) begin
          errors++;
          $display("FAIL stall_stable act=%0h exp=%0h", act, held);
        end
      end
      if (rstn && bus.m_axis_tvalid && bus.m_axis_tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected act=%0h exp=none", act);
        end else begin
          exp = exp_q.pop_front();
          if (act !== exp) begin
            errors++;
            $display("FAIL beat act=%0h exp=%0h", act, exp);
          end
        end
      end
      prev_stall = rstn && bus.m_axis_tvalid && !bus.m_axis_tready;
      held = act;
      if (rstn && bus.m_status_valid) begin
        sact = {bus.m_status_tag, bus.m_status_error};
        checks++;
        if (stat_q.size() == 0) begin
          errors++;
          $display("FAIL status_unexpected act=%0h exp=none", sact);
        end else if (sact !== stat_q[0]) begin
          errors++;
          $display("FAIL status act=%0h exp=%0h", sact, stat_q[0]);
          void'(stat_q.pop_front());
        end else begin
          void'(stat_q.pop_front());
        end
      end
    end
  end

  // driver tasks
  task automatic write_cmd(input logic [1:0] mask, input logic [7:0] row,
                           input logic [63:0] be, input logic [511:0] data);
    @(posedge clk); #1;
    wr_cmd_valid = mask;
    wr_cmd_addr  = {row, row};
    wr_cmd_be    = be;
    wr_cmd_data  = data;
    @(posedge clk); #1;
    wr_cmd_valid = 2'b00;
    for (int s = 0; s < 2; s++) begin
      if (mask[s]) begin
        for (int b = 0; b < 32; b++) begin
          if (be[s*32+b]) mem_model[int'(row)*64 + s*32 + b] = data[(s*32+b)*8 +: 8];
        end
      end
    end
    @(negedge clk);
    check("wr_done_pulse", 512'(wr_done), 512'(mask));
    @(negedge clk);
    check("wr_done_clear", 512'(wr_done), 512'(0));
  endtask

  function automatic logic [511:0] model_row(input int row);
    logic [511:0] d;
    for (int b = 0; b < 64; b++) d[b*8 +: 8] = mem_model[(row % 256)*64 + b];
    return d;
  endfunction

  task automatic send_desc(input logic [13:0] addr, input logic [15:0] len,
                           input logic [7:0] tag, input logic [7:0] id,
                           input int beats, input logic [63:0] last_keep, input int hold);
    int n;
    int base;
    logic [63:0] keep;
    bus.s_desc_ram_addr = addr;
    bus.s_desc_len      = len;
    bus.s_desc_tag      = tag;
    bus.s_desc_id       = id;
    if (hold > 0) begin
      @(posedge clk); #1;
      enable = 1'b0;
      bus.s_desc_valid = 1'b1;
      repeat (hold) begin
        @(negedge clk);
        check("desc_ready_gated", 512'(bus.s_desc_ready), 512'(0));
        check("no_stream_disabled", 512'(bus.m_axis_tvalid), 512'(0));
      end
    end
    base = int'(addr) / 64;
    for (int k = 0; k < beats; k++) begin
      keep = (k == beats - 1) ? last_keep : '1;
      exp_q.push_back({id, 1'(k == beats - 1), keep, model_row(base + k)});
    end
    stat_q.push_back({tag, 4'h0});
    @(posedge clk); #1;
    enable = 1'b1;
    bus.s_desc_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.s_desc_ready && n < 200);
    check("desc_accept", 512'(bus.s_desc_ready), 512'(1));
    @(posedge clk); #1;
    bus.s_desc_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || stat_q.size() != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check(name, 512'(exp_q.size() + stat_q.size()), 512'(0));
  endtask

  // stimulus
  initial begin
    logic [511:0] d;
    int n;
    for (int i = 0; i < 16384; i++) mem_model[i] = 8'h00;
    rstn = 1'b0;
    enable = 1'b1;
    wr_cmd_valid = 2'b00;
    wr_cmd_be = '0;
    wr_cmd_addr = '0;
    wr_cmd_data = '0;
    bus.s_desc_valid = 1'b0;
    bus.s_desc_ram_addr = '0;
    bus.s_desc_len = '0;
    bus.s_desc_tag = '0;
    bus.s_desc_id = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_desc_ready", 512'(bus.s_desc_ready), 512'(0));
    check("rst_tvalid", 512'(bus.m_axis_tvalid), 512'(0));
    check("rst_status", 512'(bus.m_status_valid), 512'(0));
    check("rst_wr_done", 512'(wr_done), 512'(0));
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    check("wr_cmd_ready", 512'(wr_cmd_ready), 512'(2'b11));
    check("state_idle", 512'(state_dbg), 512'(0));
    check("desc_ready_idle", 512'(bus.s_desc_ready), 512'(1));

    // rows 0..7 hold byte i = i mod 256; row 255 a distinct pattern
    for (int r = 0; r < 8; r++) begin
      for (int b = 0; b < 64; b++) d[b*8 +: 8] = 8'(r*64 + b);
      write_cmd(2'b11, 8'(r), '1, d);
    end
    for (int b = 0; b < 64; b++) d[b*8 +: 8] = 8'(b) ^ 8'h5A;
    write_cmd(2'b11, 8'd255, '1, d);

    // 128 bytes, two full beats, first-beat latency bound
    send_desc(14'd0, 16'd128, 8'd1, 8'd5, 2, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.m_axis_tvalid && n < 20);
    checks++;
    if (n > 5) begin
      errors++;
      $display("FAIL first_tvalid_latency act=%0d exp<=5", n);
    end
    wait_done("desc_len128_done");

    send_desc(14'd0, 16'd100, 8'd2, 8'd6, 2, 64'h0000_000F_FFFF_FFFF, 0);
    wait_done("desc_len100_done");

    tready_mode = 2;
    send_desc(14'd0, 16'd512, 8'd3, 8'd7, 8, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    wait_done("desc_len512_stall_done");
    tready_mode = 1;

    send_desc(14'd64, 16'd0, 8'd4, 8'd2, 0, 64'h0, 0);
    wait_done("desc_len0_done");

    // unaligned start in the top row: low bits ignored, wraps to row 0
    send_desc(14'h3FC5, 16'd128, 8'd5, 8'd8, 2, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    wait_done("desc_wrap_done");

    // byte-masked segment-0 write over a zeroed row, then an empty-mask write
    write_cmd(2'b11, 8'd0, '1, '0);
    write_cmd(2'b01, 8'd0, 64'h1, 512'hAB);
    write_cmd(2'b10, 8'd0, 64'h0, '1);
    send_desc(14'd0, 16'd64, 8'd6, 8'd1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    wait_done("desc_masked_row_done");

    // descriptor waits while enable is low
    send_desc(14'd128, 16'd65, 8'd8, 8'd4, 2, 64'h1, 8);
    wait_done("desc_enable_done");

    // reset after the first of eight beats
    tready_mode = 0;
    bus.m_axis_tready = 1'b0;
    send_desc(14'd0, 16'd512, 8'd9, 8'd3, 8, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.m_axis_tvalid && n < 20);
    check("reset_test_tvalid", 512'(bus.m_axis_tvalid), 512'(1));
    @(posedge clk); #1;
    bus.m_axis_tready = 1'b1;
    @(posedge clk); #1;
    bus.m_axis_tready = 1'b0;
    rstn = 1'b0;
    @(posedge clk);
    exp_q.delete();
    stat_q.delete();
    #1;
    bus.m_axis_tready = 1'b1;
    @(negedge clk);
    check("abort_tvalid", 512'(bus.m_axis_tvalid), 512'(0));
    check("abort_status", 512'(bus.m_status_valid), 512'(0));
    @(posedge clk); #1;
    rstn = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("abort_idle_tvalid", 512'(bus.m_axis_tvalid), 512'(0));
    end
    tready_mode = 1;
    send_desc(14'd0, 16'd128, 8'd10, 8'd9, 2, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    wait_done("desc_after_reset_done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
